// File: rtl/fpu.sv
// ============================================================================
// fpu -- free-running multi-cycle floating-point adder
//
// Number format (32 bits): {sign[31], exp[30:25], frac[24:0]}
//   value = (-1)^sign * 1.frac * 2^(exp-31)
//   exp == 0  : zero (frac ignored, no denormals)
//   exp == 63 : saturated / overflow magnitude
//
// The block cycles through LOAD -> ALIGN -> ADD -> NORM -> ROUND, one state
// per clock. It samples the operands in LOAD and registers the sum and a
// one-hot status code in ROUND. The outputs hold their value between
// ROUND states.
//
// Ports:
//   clock      in   1  system clock, all state changes on the rising edge
//   reset      in   1  synchronous active-high reset; clears FSM and outputs
//   op_A_in    in  32  operand A
//   op_B_in    in  32  operand B
//   data_out   out 32  registered sum
//   status_out out  4  one-hot status: [0] EXACT [1] OVERFLOW
//                      [2] UNDERFLOW [3] INEXACT
//
// Build option:
//   FPU_ROUND_NEAREST_EN  defined   -> round to nearest, ties to even
//                         undefined -> truncate (round toward zero)
// ============================================================================
module fpu (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] op_A_in,
    input  logic [31:0] op_B_in,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND
    } state_t;

    localparam logic [3:0] STATUS_EXACT     = 4'b0001;
    localparam logic [3:0] STATUS_OVERFLOW  = 4'b0010;
    localparam logic [3:0] STATUS_UNDERFLOW = 4'b0100;
    localparam logic [3:0] STATUS_INEXACT   = 4'b1000;

    // Extended mantissa layout used from ALIGN onward (29 bits):
    //   [28] hidden bit, [27:3] fraction, [2] guard, [1] round, [0] sticky

    state_t state;

    // LOAD stage registers: unpacked operands with hidden bit inserted
    logic        sign_a_q, sign_b_q;
    logic [5:0]  exp_a_q, exp_b_q;
    logic [25:0] mant_a_q, mant_b_q;

    // ALIGN stage registers: larger operand first, smaller one shifted
    logic        sign_l_q;
    logic        eff_sub_q;
    logic [5:0]  exp_l_q;
    logic [28:0] mant_l_q;
    logic [28:0] mant_s_q;

    // ADD stage registers: raw sum with carry-out bit at [29]
    logic        sign_r_q;
    logic [5:0]  exp_r_q;
    logic [29:0] sum_q;

    // NORM stage registers: exponent is signed so it can go below zero
    logic               sign_n_q;
    logic               zero_n_q;
    logic signed [7:0]  exp_n_q;
    logic [28:0]        norm_q;

    // ------------------------------------------------------------------------
    // Leading-zero count over the 29-bit extended mantissa (29 when all zero)
    // ------------------------------------------------------------------------
    function automatic logic [4:0] lzc29(input logic [28:0] v);
        logic [4:0] count;
        count = 5'd29;
        // Ascending scan: the last set bit found is the most significant one.
        for (int i = 0; i < 29; i++) begin
            if (v[i]) count = 5'(28 - i);
        end
        return count;
    endfunction

    // ------------------------------------------------------------------------
    // LOAD: unpack, hidden bit is 0 for a zero exponent (fraction ignored)
    // ------------------------------------------------------------------------
    logic [25:0] mant_a_d, mant_b_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        mant_a_d = 26'h0;
        mant_b_d = 26'h0;
        if (op_A_in[30:25] != 6'd0) mant_a_d = {1'b1, op_A_in[24:0]};
        if (op_B_in[30:25] != 6'd0) mant_b_d = {1'b1, op_B_in[24:0]};
    end

    // ------------------------------------------------------------------------
    // ALIGN: order by magnitude, barrel-shift the smaller mantissa right
    // ------------------------------------------------------------------------
    logic        a_ge_b;
    logic        sign_big;
    logic [5:0]  exp_big, exp_small;
    logic [25:0] mant_big, mant_small;
    logic [5:0]  exp_diff;
    logic [55:0] shift_wide;
    logic [28:0] aligned_small;

    always_comb begin
        a_ge_b     = {exp_a_q, mant_a_q} >= {exp_b_q, mant_b_q};
        sign_big   = a_ge_b ? sign_a_q : sign_b_q;
        exp_big    = a_ge_b ? exp_a_q  : exp_b_q;
        exp_small  = a_ge_b ? exp_b_q  : exp_a_q;
        mant_big   = a_ge_b ? mant_a_q : mant_b_q;
        mant_small = a_ge_b ? mant_b_q : mant_a_q;
        exp_diff   = exp_big - exp_small;

        // Upper 28 bits keep mantissa plus guard/round; the lower 28 bits
        // catch everything shifted past the round bit for the sticky OR.
        shift_wide = {mant_small, 2'b00, 28'h0} >> exp_diff;

        if (exp_diff > 6'd27) begin
            aligned_small = {28'h0, |mant_small};
        end else begin
            aligned_small = {shift_wide[55:28], |shift_wide[27:0]};
        end
    end

    // ------------------------------------------------------------------------
    // ADD: magnitude add or subtract; larger minus smaller never goes negative
    // ------------------------------------------------------------------------
    logic [29:0] sum_d;

    always_comb begin
        if (eff_sub_q) sum_d = {1'b0, mant_l_q} - {1'b0, mant_s_q};
        else           sum_d = {1'b0, mant_l_q} + {1'b0, mant_s_q};
    end

    // ------------------------------------------------------------------------
    // NORM: right shift on carry-out, otherwise left shift by leading zeros
    // ------------------------------------------------------------------------
    logic [4:0]         lz;
    logic [28:0]        norm_d;
    logic signed [7:0]  exp_norm_d;
    logic               zero_d;

    always_comb begin
        lz         = lzc29(sum_q[28:0]);
        zero_d     = (sum_q == 30'h0);
        norm_d     = sum_q[28:0] << lz;
        exp_norm_d = $signed({2'b00, exp_r_q}) - $signed({3'b000, lz});
        if (sum_q[29]) begin
            // Bit shifted out of the bottom folds into sticky.
            norm_d     = {sum_q[29:2], sum_q[1] | sum_q[0]};
            exp_norm_d = $signed({2'b00, exp_r_q}) + 8'sd1;
        end
    end

    // ------------------------------------------------------------------------
    // ROUND: round, renormalize on carry, classify the result
    // ------------------------------------------------------------------------
    logic               inexact;
    logic               round_up;
    logic [26:0]        rounded;
    logic [24:0]        frac_f;
    logic signed [7:0]  exp_f;
    logic [31:0]        result_d;
    logic [3:0]         status_d;

    always_comb begin
        inexact = |norm_q[2:0];
`ifdef FPU_ROUND_NEAREST_EN
        // Round up above the halfway point, or on a tie when the LSB is odd.
        round_up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
`else
        round_up = 1'b0;
`endif
        rounded = {1'b0, norm_q[28:3]} + {26'h0, round_up};

        if (rounded[26]) begin
            frac_f = rounded[25:1];
            exp_f  = exp_n_q + 8'sd1;
        end else begin
            frac_f = rounded[24:0];
            exp_f  = exp_n_q;
        end

        if (zero_n_q) begin
            result_d = 32'h0;
            status_d = STATUS_EXACT;
        end else if (exp_f >= 8'sd63) begin
            result_d = {sign_n_q, 6'h3F, 25'h0};
            status_d = STATUS_OVERFLOW;
        end else if (exp_f <= 8'sd0) begin
            result_d = {sign_n_q, 31'h0};
            status_d = STATUS_UNDERFLOW;
        end else begin
            result_d = {sign_n_q, exp_f[5:0], frac_f};
            status_d = inexact ? STATUS_INEXACT : STATUS_EXACT;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer and pipeline registers
    // ------------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the datapath registers are cleared along with the FSM so
            // an aborted computation leaves no stale operands behind.
            state      <= ST_LOAD;
            data_out   <= 32'h0;
            status_out <= 4'h0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            exp_a_q    <= 6'h0;
            exp_b_q    <= 6'h0;
            mant_a_q   <= 26'h0;
            mant_b_q   <= 26'h0;
            sign_l_q   <= 1'b0;
            eff_sub_q  <= 1'b0;
            exp_l_q    <= 6'h0;
            mant_l_q   <= 29'h0;
            mant_s_q   <= 29'h0;
            sign_r_q   <= 1'b0;
            exp_r_q    <= 6'h0;
            sum_q      <= 30'h0;
            sign_n_q   <= 1'b0;
            zero_n_q   <= 1'b0;
            exp_n_q    <= 8'sd0;
            norm_q     <= 29'h0;
        end else begin
            case (state)
                ST_LOAD: begin
                    sign_a_q <= op_A_in[31];
                    sign_b_q <= op_B_in[31];
                    exp_a_q  <= op_A_in[30:25];
                    exp_b_q  <= op_B_in[30:25];
                    mant_a_q <= mant_a_d;
                    mant_b_q <= mant_b_d;
                    state    <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    sign_l_q  <= sign_big;
                    eff_sub_q <= sign_a_q ^ sign_b_q;
                    exp_l_q   <= exp_big;
                    mant_l_q  <= {mant_big, 3'b000};
                    mant_s_q  <= aligned_small;
                    state     <= ST_ADD;
                end
                ST_ADD: begin
                    sign_r_q <= sign_l_q;
                    exp_r_q  <= exp_l_q;
                    sum_q    <= sum_d;
                    state    <= ST_NORM;
                end
                ST_NORM: begin
                    // Exact cancellation always yields +0.
                    sign_n_q <= zero_d ? 1'b0 : sign_r_q;
                    zero_n_q <= zero_d;
                    exp_n_q  <= exp_norm_d;
                    norm_q   <= norm_d;
                    state    <= ST_ROUND;
                end
                ST_ROUND: begin
                    data_out   <= result_d;
                    status_out <= status_d;
                    state      <= ST_LOAD;
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu.sv
// ============================================================================
// tb_fpu -- directed self-checking bench for the fpu adder
// ============================================================================
module tb_fpu;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    fpu dut (
        .clock      (clock),
        .reset      (reset),
        .op_A_in    (op_a),
        .op_B_in    (op_b),
        .data_out   (data_out),
        .status_out (status_out)
    );

`ifdef FPU_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    localparam int NV = 14;
    string       vn [NV];
    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    logic [31:0] vd [NV];
    logic [3:0]  vs [NV];

    task automatic load_table();
        vn[0]  = "one_minus_one";   va[0]  = 32'h3E000000; vb[0]  = 32'hBE000000; vd[0]  = 32'h00000000; vs[0]  = 4'b0001;
        vn[1]  = "1p5_plus_0p5";    va[1]  = 32'h3F000000; vb[1]  = 32'h3C000000; vd[1]  = 32'h40000000; vs[1]  = 4'b0001;
        vn[2]  = "one_plus_zero";   va[2]  = 32'h3E000000; vb[2]  = 32'h00000000; vd[2]  = 32'h3E000000; vs[2]  = 4'b0001;
        vn[3]  = "zero_plus_one";   va[3]  = 32'h00000000; vb[3]  = 32'h3E000000; vd[3]  = 32'h3E000000; vs[3]  = 4'b0001;
        vn[4]  = "negzero_negzero"; va[4]  = 32'h80000000; vb[4]  = 32'h80000000; vd[4]  = 32'h00000000; vs[4]  = 4'b0001;
        vn[5]  = "1p5_plus_2p25";   va[5]  = 32'h3F000000; vb[5]  = 32'h40400000; vd[5]  = 32'h41C00000; vs[5]  = 4'b0001;
        vn[6]  = "1p5_minus_1";     va[6]  = 32'h3F000000; vb[6]  = 32'hBE000000; vd[6]  = 32'h3C000000; vs[6]  = 4'b0001;
        vn[7]  = "1_minus_1p5";     va[7]  = 32'h3E000000; vb[7]  = 32'hBF000000; vd[7]  = 32'hBC000000; vs[7]  = 4'b0001;
        vn[8]  = "overflow";        va[8]  = 32'h7C000000; vb[8]  = 32'h7C000000; vd[8]  = 32'h7E000000; vs[8]  = 4'b0010;
        vn[9]  = "underflow";       va[9]  = 32'h02000001; vb[9]  = 32'h82000000; vd[9]  = 32'h00000000; vs[9]  = 4'b0100;
        vn[10] = "sticky_only";     va[10] = 32'h3E000000; vb[10] = 32'h04000001; vd[10] = 32'h3E000000; vs[10] = 4'b1000;
        // 1.0 + (2^-26 * (1+2^-25)): above half an ulp
        vn[11] = "above_half";      va[11] = 32'h3E000000; vb[11] = 32'h0A000001;
        vd[11] = RNE ? 32'h3E000001 : 32'h3E000000;                                          vs[11] = 4'b1000;
        // 1.0 + 2^-26: exact tie, even LSB stays
        vn[12] = "tie_even";        va[12] = 32'h3E000000; vb[12] = 32'h0A000000; vd[12] = 32'h3E000000; vs[12] = 4'b1000;
        // (1.0 + 2^-25) + 2^-26: exact tie, odd LSB rounds up under RNE
        vn[13] = "tie_odd";         va[13] = 32'h3E000001; vb[13] = 32'h0A000000;
        vd[13] = RNE ? 32'h3E000002 : 32'h3E000001;                                          vs[13] = 4'b1000;
    endtask

    // Returns at a falling edge with reset low; the next rising edge is LOAD.
    task automatic apply_reset();
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op_a  = 32'h3F000000;
        op_b  = 32'h3C000000;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (data_out !== 32'h0) $display("FAIL reset_data: got %h want %h", data_out, 32'h0);
        else passed++;
        checks++;
        if (status_out !== 4'h0) $display("FAIL reset_status: got %b want %b", status_out, 4'h0);
        else passed++;
        // Result must not appear before the fifth edge after reset release.
        @(negedge clock) reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (data_out !== 32'h0 || status_out !== 4'h0)
            $display("FAIL latency_early: got %h/%b want %h/%b", data_out, status_out, 32'h0, 4'h0);
        else passed++;
        @(posedge clock);
        #1;
        checks++;
        if (data_out !== 32'h40000000 || status_out !== 4'b0001)
            $display("FAIL latency_fifth: got %h/%b want %h/%b", data_out, status_out, 32'h40000000, 4'b0001);
        else passed++;
    endtask

    task automatic test_vectors();
        for (int i = 0; i < NV; i++) begin
            op_a = va[i];
            op_b = vb[i];
            apply_reset();
            repeat (5) @(posedge clock);
            #1;
            checks++;
            if (data_out !== vd[i]) $display("FAIL %s_data: got %h want %h", vn[i], data_out, vd[i]);
            else passed++;
            checks++;
            if (status_out !== vs[i]) $display("FAIL %s_status: got %b want %b", vn[i], status_out, vs[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        op_a = 32'h3F000000;
        op_b = 32'h3C000000;
        apply_reset();
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (data_out !== 32'h40000000) $display("FAIL b2b_first: got %h want %h", data_out, 32'h40000000);
        else passed++;
        // Edge 6 is LOAD of the next pass; changing operands afterwards must
        // not disturb that pass, and outputs hold meanwhile.
        @(posedge clock);
        #1;
        op_b = 32'h40400000;
        for (int k = 7; k <= 10; k++) begin
            @(posedge clock);
            #1;
            checks++;
            if (data_out !== 32'h40000000 || status_out !== 4'b0001)
                $display("FAIL b2b_hold_edge%0d: got %h/%b want %h/%b", k, data_out, status_out, 32'h40000000, 4'b0001);
            else passed++;
        end
        found = 1'b0;
        for (int k = 0; k < 9 && !found; k++) begin
            @(posedge clock);
            #1;
            if (data_out === 32'h41C00000) found = 1'b1;
        end
        checks++;
        if (!found || status_out !== 4'b0001)
            $display("FAIL b2b_second: got %h/%b want %h/%b within 9 cycles", data_out, status_out, 32'h41C00000, 4'b0001);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        op_a = 32'h3F000000;
        op_b = 32'h3C000000;
        apply_reset();
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (data_out !== 32'h40000000) $display("FAIL midrst_before: got %h want %h", data_out, 32'h40000000);
        else passed++;
        // Edges 6 (LOAD) and 7 (ALIGN) leave the FSM in ADD.
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (data_out !== 32'h0 || status_out !== 4'h0)
            $display("FAIL midrst_cleared: got %h/%b want %h/%b", data_out, status_out, 32'h0, 4'h0);
        else passed++;
        @(negedge clock) reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (data_out !== 32'h0) $display("FAIL midrst_restart_early: got %h want %h", data_out, 32'h0);
        else passed++;
        @(posedge clock);
        #1;
        checks++;
        if (data_out !== 32'h40000000 || status_out !== 4'b0001)
            $display("FAIL midrst_restart: got %h/%b want %h/%b", data_out, status_out, 32'h40000000, 4'b0001);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        op_a  = 32'h0;
        op_b  = 32'h0;
        load_table();
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
